// File: rtl/uart_rx.sv
// 8N1 serial receiver with 16x oversampling and a runtime-loadable baud divisor.
// Delivers received bytes as single-cycle strobes; framing errors are flagged separately.
module uart_rx #(
  parameter logic [15:0] BAUD_DEFAULT = 16'd26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        latch_baud,
  input  logic [15:0] baud_word,
  input  logic        rx,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        frame_err,
  output logic        rx_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t      r_state;
  logic [1:0]  r_sync;
  logic [15:0] r_baud;
  logic [15:0] r_div_cnt;
  logic [3:0]  r_smp;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shreg;
  logic [7:0]  r_rx_data;
  logic        r_rx_valid;
  logic        r_frame_err;
  logic        r_rx_busy;

  logic w_rx_s;
  logic w_tick;
  logic w_mid;

  assign w_rx_s = r_sync[1];
  assign w_tick = (r_div_cnt == r_baud);
  assign w_mid  = w_tick && (r_smp == 4'd7);

  // NOTE: every register here is sequential state, so it is written only with
  // non-blocking assignments; blocking ones would make later reads in this
  // block see the new value and break the one-clock pipelining.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_sync      <= 2'b11;
      r_baud      <= BAUD_DEFAULT;
      r_div_cnt   <= '0;
      r_smp       <= '0;
      r_bit_idx   <= '0;
      r_shreg     <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_rx_busy   <= 1'b0;
    end else begin
      r_sync      <= {r_sync[0], rx};
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;

      if (latch_baud) begin
        // A new divisor invalidates any frame timing already under way.
        r_baud    <= baud_word;
        r_div_cnt <= '0;
        r_smp     <= '0;
        r_state   <= S_IDLE;
        r_rx_busy <= 1'b0;
      end else if (!en) begin
        r_div_cnt <= '0;
        r_smp     <= '0;
        r_state   <= S_IDLE;
        r_rx_busy <= 1'b0;
      end else begin
        // Counters sit at zero in IDLE so START always begins a fresh bit period.
        if (r_state == S_IDLE) begin
          r_div_cnt <= '0;
          r_smp     <= '0;
        end else if (w_tick) begin
          r_div_cnt <= '0;
          r_smp     <= r_smp + 4'd1;
        end else begin
          r_div_cnt <= r_div_cnt + 16'd1;
        end

        unique case (r_state)
          S_IDLE: begin
            if (!w_rx_s) begin
              r_state   <= S_START;
              r_rx_busy <= 1'b1;
            end
          end
          S_START: begin
            if (w_mid) begin
              if (!w_rx_s) begin
                r_state   <= S_DATA;
                r_bit_idx <= '0;
              end else begin
                r_state   <= S_IDLE;
                r_rx_busy <= 1'b0;
              end
            end
          end
          S_DATA: begin
            if (w_mid) begin
              r_shreg <= {w_rx_s, r_shreg[7:1]};
              if (r_bit_idx == 3'd7) begin
                r_state <= S_STOP;
              end else begin
                r_bit_idx <= r_bit_idx + 3'd1;
              end
            end
          end
          S_STOP: begin
            if (w_mid) begin
              if (w_rx_s) begin
                r_rx_data  <= r_shreg;
                r_rx_valid <= 1'b1;
                r_state    <= S_IDLE;
                r_rx_busy  <= 1'b0;
              end else begin
                r_frame_err <= 1'b1;
                r_state     <= S_WAIT_HIGH;
              end
            end
          end
          S_WAIT_HIGH: begin
            // A held-low line (break) must not be mistaken for a new start bit.
            if (w_rx_s) begin
              r_state   <= S_IDLE;
              r_rx_busy <= 1'b0;
            end
          end
          default: begin
            r_state   <= S_IDLE;
            r_rx_busy <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign rx_busy   = r_rx_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of 8N1 frames plus hand-written sequences for
// false start, mid-frame baud change, reset and enable drop.
module tb_uart_rx;

  logic        clk;
  logic        rst;
  logic        en;
  logic        latch_baud;
  logic [15:0] baud_word;
  logic        rx;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        frame_err;
  logic        rx_busy;

  uart_rx dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .latch_baud (latch_baud),
    .baud_word  (baud_word),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .rx_busy    (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_valid  = 0;
  int         n_ferr   = 0;
  int         n_both   = 0;
  int         n_busy   = 0;
  int         strobe_cyc = 0;
  logic [7:0] last_data = 8'h00;

  // Strobe monitor: counts high cycles so a stretched pulse shows up as >1.
  always @(negedge clk) begin
    if (rx_valid) begin
      n_valid++;
      last_data  = rx_data;
      strobe_cyc = cyc;
    end
    if (frame_err) begin
      n_ferr++;
      strobe_cyc = cyc;
    end
    if (rx_valid && frame_err) n_both++;
    if (rx_busy) n_busy++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_latch(input logic [15:0] w);
    baud_word  = w;
    latch_baud = 1'b1;
    @(negedge clk);
    latch_baud = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int bp, output int s);
    rx = 1'b0;
    s  = cyc;
    repeat (bp) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (bp) @(negedge clk);
    end
    rx = stop;
    repeat (bp) @(negedge clk);
  endtask

  task automatic send_partial(input logic [7:0] d, input int nbits, input int bp);
    rx = 1'b0;
    repeat (bp) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      rx = d[i];
      repeat (bp) @(negedge clk);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_ok;
    int         hold_low;
    int         exp_valid;
    int         exp_ferr;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int s;
    int v0;
    int f0;
    int b0;

    // Frames at baud_reg=3 (64 clk/bit); strobe expected 3+152*4=611 clocks after start edge.
    vecs[0] = '{8'hA5, 1'b1, 0,   1, 0, 8'hA5};
    vecs[1] = '{8'h00, 1'b1, 0,   1, 0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 0,   1, 0, 8'hFF};
    vecs[3] = '{8'h3C, 1'b1, 0,   1, 0, 8'h3C};
    vecs[4] = '{8'h81, 1'b0, 200, 0, 1, 8'h3C};
    vecs[5] = '{8'h96, 1'b1, 0,   1, 0, 8'h96};

    rst = 1'b0; en = 1'b0; latch_baud = 1'b0; baud_word = 16'h0000; rx = 1'b1;
    repeat (3) @(negedge clk);
    check("reset rx_data", rx_data, 8'h00);
    check("reset rx_valid", rx_valid, 1'b0);
    check("reset frame_err", frame_err, 1'b0);
    check("reset rx_busy", rx_busy, 1'b0);
    rst = 1'b1;
    en  = 1'b1;
    do_latch(16'd3);
    repeat (5) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      v0 = n_valid;
      f0 = n_ferr;
      send_frame(vecs[i].data, vecs[i].stop_ok, 64, s);
      if (vecs[i].hold_low > 0) begin
        repeat (vecs[i].hold_low) @(negedge clk);
        check($sformatf("vec%0d busy while line held low", i), rx_busy, 1'b1);
        rx = 1'b1;
        repeat (700) @(negedge clk);
        check($sformatf("vec%0d busy after line high", i), rx_busy, 1'b0);
      end
      check($sformatf("vec%0d rx_valid cycles", i), n_valid - v0, vecs[i].exp_valid);
      check($sformatf("vec%0d frame_err cycles", i), n_ferr - f0, vecs[i].exp_ferr);
      check($sformatf("vec%0d rx_data", i), rx_data, vecs[i].exp_data);
      check($sformatf("vec%0d strobe latency", i), strobe_cyc - s, 611);
      if (vecs[i].exp_valid > 0)
        check($sformatf("vec%0d data at strobe", i), last_data, vecs[i].exp_data);
    end

    // False start: 20-clock glitch, START entered at +3, mid-sample drops busy at +35.
    repeat (20) @(negedge clk);
    v0 = n_valid; f0 = n_ferr;
    rx = 1'b0;
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (14) @(negedge clk);
    check("false start busy at +34", rx_busy, 1'b1);
    @(negedge clk);
    check("false start busy at +35", rx_busy, 1'b0);
    repeat (700) @(negedge clk);
    check("false start no rx_valid", n_valid - v0, 0);
    check("false start no frame_err", n_ferr - f0, 0);

    // Baud change during DATA aborts the frame; then receive at 128 clk/bit.
    v0 = n_valid; f0 = n_ferr;
    send_partial(8'hC3, 3, 64);
    rx = 1'b1;
    do_latch(16'd7);
    check("baud change busy drops", rx_busy, 1'b0);
    repeat (1500) @(negedge clk);
    check("baud change no rx_valid", n_valid - v0, 0);
    check("baud change no frame_err", n_ferr - f0, 0);
    check("baud change rx_data kept", rx_data, 8'h96);
    send_frame(8'h5A, 1'b1, 128, s);
    rx = 1'b1;
    check("new baud rx_data", rx_data, 8'h5A);
    check("new baud latency", strobe_cyc - s, 1219);
    check("new baud rx_valid cycles", n_valid - v0, 1);

    // Reset during DATA: outputs cleared and divisor back to the default.
    send_partial(8'h33, 3, 128);
    rst = 1'b0;
    rx  = 1'b1;
    @(negedge clk);
    check("mid reset rx_data", rx_data, 8'h00);
    check("mid reset rx_valid", rx_valid, 1'b0);
    check("mid reset frame_err", frame_err, 1'b0);
    check("mid reset rx_busy", rx_busy, 1'b0);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    v0 = n_valid;
    send_frame(8'hE7, 1'b1, 432, s);
    rx = 1'b1;
    check("default baud rx_data", rx_data, 8'hE7);
    check("default baud latency", strobe_cyc - s, 4107);
    check("default baud rx_valid cycles", n_valid - v0, 1);

    // Enable drop during DATA, reception blocked while low, latch still honoured.
    do_latch(16'd3);
    repeat (5) @(negedge clk);
    v0 = n_valid; f0 = n_ferr;
    send_partial(8'h0F, 4, 64);
    en = 1'b0;
    rx = 1'b1;
    @(negedge clk);
    check("en drop busy", rx_busy, 1'b0);
    repeat (800) @(negedge clk);
    do_latch(16'd1);
    b0 = n_busy;
    send_frame(8'h11, 1'b1, 32, s);
    rx = 1'b1;
    repeat (50) @(negedge clk);
    check("en low busy cycles", n_busy - b0, 0);
    check("en low no rx_valid", n_valid - v0, 0);
    check("en low no frame_err", n_ferr - f0, 0);
    check("en low rx_data kept", rx_data, 8'hE7);
    en = 1'b1;
    repeat (5) @(negedge clk);
    send_frame(8'h42, 1'b1, 32, s);
    rx = 1'b1;
    check("re-enable rx_data", rx_data, 8'h42);
    check("re-enable latency", strobe_cyc - s, 307);
    check("re-enable rx_valid cycles", n_valid - v0, 1);

    repeat (20) @(negedge clk);
    check("valid and frame_err overlap", n_both, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
